osd_reliability_sorter: RTL and testbench

Sequential sorter that turns a frame of N signed channel LLRs into the reliability permutation for ordered-statistics decoding. Runs an N-pass odd-even transposition sort on LLR magnitudes, carrying the original index and hard-decision sign with each key. Sits directly upstream of the generator-column permuter: `lambda1` drives the permuter's index input unchanged, and the permuted hard decisions feed the later re-encoding stages.

---
 rtl/osd_pkg.sv | 24 ++
 rtl/osd_reliability_sorter_if.sv | 46 ++++
 rtl/osd_cmp_swap.sv | 27 ++
 rtl/osd_reliability_sorter.sv | 194 +++++++++++++++++++
 tb/tb_osd_reliability_sorter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/osd_pkg.sv
// Shared definitions for the OSD front end (reliability sorter and generator-column permuter).
// Contents:
//   OSD_N, OSD_W, OSD_IDX_W : default codeword length, LLR width and index width
//   osd_state_e             : sorter FSM states
//   osd_key_t               : sort key {mag, idx, sgn} at the default widths
package osd_pkg;

    localparam int unsigned OSD_N     = 8;
    localparam int unsigned OSD_W     = 8;
    localparam int unsigned OSD_IDX_W = $clog2(OSD_N);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSort = 2'd1,
        StDone = 2'd2
    } osd_state_e;

    typedef struct packed {
        logic [OSD_W-1:0]     mag;
        logic [OSD_IDX_W-1:0] idx;
        logic                 sgn;
    } osd_key_t;

endpackage

// File: rtl/osd_reliability_sorter_if.sv
// Frame-in / permutation-out bundle of the reliability sorter.
// Signals:
//   in_valid, in_ready, llr_flat             : input frame handshake, LLR i at [i*W +: W]
//   out_valid, out_ready                     : result handshake
//   lambda1, mag_sorted, hd_perm             : sorted indices, magnitudes and hard decisions
// Modports: master drives frames and accepts results, slave is the sorter.
interface osd_reliability_sorter_if
    import osd_pkg::*;
#(
    parameter int unsigned N     = OSD_N,
    parameter int unsigned W     = OSD_W,
    parameter int unsigned IDX_W = $clog2(N)
);

    logic               in_valid;
    logic               in_ready;
    logic [N*W-1:0]     llr_flat;
    logic               out_valid;
    logic               out_ready;
    logic [N*IDX_W-1:0] lambda1;
    logic [N*W-1:0]     mag_sorted;
    logic [N-1:0]       hd_perm;

    modport master (
        output in_valid,
        output llr_flat,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  lambda1,
        input  mag_sorted,
        input  hd_perm
    );

    modport slave (
        input  in_valid,
        input  llr_flat,
        input  out_ready,
        output in_ready,
        output out_valid,
        output lambda1,
        output mag_sorted,
        output hd_perm
    );

endinterface

// File: rtl/osd_cmp_swap.sv
// One compare-swap cell of the odd-even transposition network.
// Ports:
//   a_i       : key at the lower position j
//   b_i       : key at position j+1
//   hi_o      : key that goes to position j (larger magnitude)
//   lo_o      : key that goes to position j+1
//   swapped_o : the pair was exchanged
// Swaps only on strictly greater magnitude so equal keys keep their order.
module osd_cmp_swap
    import osd_pkg::*;
#(
    parameter type key_t = osd_key_t
) (
    input  key_t a_i,
    input  key_t b_i,
    output key_t hi_o,
    output key_t lo_o,
    output logic swapped_o
);

    always_comb begin
        swapped_o = (b_i.mag > a_i.mag);
        hi_o      = swapped_o ? b_i : a_i;
        lo_o      = swapped_o ? a_i : b_i;
    end

endmodule

// File: rtl/osd_reliability_sorter.sv
// Reliability sorter for ordered-statistics decoding: sorts a frame of N signed LLRs by
// magnitude (descending, stable) with an N-pass odd-even transposition sort, one pass per cycle,
// carrying the original index and hard-decision sign with each key.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, aborts any frame in flight
//   bus_io : osd_reliability_sorter_if slave (frame in, permutation out)
// Optional feature macro OSD_SORTER_EARLY_EXIT_EN: when defined, SORT leaves after two
// consecutive swap-free passes; otherwise every frame takes exactly N passes.
module osd_reliability_sorter
    import osd_pkg::*;
#(
    parameter int unsigned N     = OSD_N,
    parameter int unsigned W     = OSD_W,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    osd_reliability_sorter_if.slave bus_io
);

    localparam int unsigned NPAIR = N / 2;
    localparam int unsigned PW    = IDX_W + 1;

    typedef struct packed {
        logic [W-1:0]     mag;
        logic [IDX_W-1:0] idx;
        logic             sgn;
    } key_t;

    osd_state_e       state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    key_t             keys_q [N];
    key_t             keys_d [N];
    key_t             load_keys [N];
    key_t             even_nxt [N];
    key_t             odd_nxt [N];
    key_t             cmp_a [NPAIR];
    key_t             cmp_b [NPAIR];
    key_t             cmp_hi [NPAIR];
    key_t             cmp_lo [NPAIR];
    logic [NPAIR-1:0] cmp_swp;
    logic [NPAIR-1:0] pass_swp;
    logic             odd_pass;

    assign odd_pass = p_q[0];

    // Key load: |x| as W-bit unsigned, so the most negative value maps to 2^(W-1).
    for (genvar i = 0; i < N; i++) begin : g_load
        logic [W-1:0] llr;
        assign llr          = bus_io.llr_flat[i*W +: W];
        assign load_keys[i] = '{
            mag: (llr[W-1] ? ((~llr) + W'(1)) : llr),
            idx: IDX_W'(i),
            sgn: llr[W-1]
        };
    end

    // Cell k handles (2k,2k+1) on even passes and (2k+1,2k+2) on odd passes. When N is even the
    // last cell has no odd-pass partner and its output is discarded on odd passes.
    for (genvar k = 0; k < NPAIR; k++) begin : g_pair
        localparam bit          OddOk = ((2 * k + 2) < N);
        localparam int unsigned OddB  = OddOk ? (2 * k + 2) : (2 * k + 1);

        assign cmp_a[k] = odd_pass ? keys_q[2*k+1] : keys_q[2*k];
        assign cmp_b[k] = odd_pass ? keys_q[OddB]  : keys_q[2*k+1];

        osd_cmp_swap #(
            .key_t(key_t)
        ) u_cmp (
            .a_i      (cmp_a[k]),
            .b_i      (cmp_b[k]),
            .hi_o     (cmp_hi[k]),
            .lo_o     (cmp_lo[k]),
            .swapped_o(cmp_swp[k])
        );

        assign even_nxt[2*k]   = cmp_hi[k];
        assign even_nxt[2*k+1] = cmp_lo[k];

        if (OddOk) begin : g_odd
            assign odd_nxt[2*k+1] = cmp_hi[k];
            assign odd_nxt[2*k+2] = cmp_lo[k];
            assign pass_swp[k]    = cmp_swp[k];
        end else begin : g_odd_tail
            assign odd_nxt[2*k+1] = keys_q[2*k+1];
            assign pass_swp[k]    = odd_pass ? 1'b0 : cmp_swp[k];
        end
    end

    assign odd_nxt[0] = keys_q[0];
    if ((N % 2) == 1) begin : g_even_tail
        assign even_nxt[N-1] = keys_q[N-1];
    end

`ifdef OSD_SORTER_EARLY_EXIT_EN
    // quiet_q: the previous pass of this frame made no swap.
    logic quiet_q, quiet_d;
    logic any_swap;
    assign any_swap = |pass_swp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_q <= 1'b0;
        end else begin
            quiet_q <= quiet_d;
        end
    end
`else
    logic unused_swp;
    assign unused_swp = |pass_swp;
`endif

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        keys_d  = keys_q;
`ifdef OSD_SORTER_EARLY_EXIT_EN
        quiet_d = quiet_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    keys_d  = load_keys;
                    p_d     = '0;
                    state_d = StSort;
`ifdef OSD_SORTER_EARLY_EXIT_EN
                    quiet_d = 1'b0;
`endif
                end
            end
            StSort: begin
                if (odd_pass) begin
                    keys_d = odd_nxt;
                end else begin
                    keys_d = even_nxt;
                end
                p_d = p_q + PW'(1);
                if (p_q == PW'(N - 1)) begin
                    state_d = StDone;
                end
`ifdef OSD_SORTER_EARLY_EXIT_EN
                quiet_d = ~any_swap;
                if (quiet_q && !any_swap) begin
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            p_q     <= '0;
            for (int i = 0; i < N; i++) begin
                keys_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            keys_q  <= keys_d;
        end
    end

    // Outputs come straight from the key registers; they only change while sorting or loading.
    logic [N*IDX_W-1:0] lambda_flat;
    logic [N*W-1:0]     mag_flat;
    logic [N-1:0]       hd_flat;

    always_comb begin
        lambda_flat = '0;
        mag_flat    = '0;
        hd_flat     = '0;
        for (int c = 0; c < N; c++) begin
            lambda_flat[c*IDX_W +: IDX_W] = keys_q[c].idx;
            mag_flat[c*W +: W]            = keys_q[c].mag;
            hd_flat[c]                    = keys_q[c].sgn;
        end
    end

    assign bus_io.lambda1    = lambda_flat;
    assign bus_io.mag_sorted = mag_flat;
    assign bus_io.hd_perm    = hd_flat;
    assign bus_io.in_ready   = (state_q == StIdle);
    assign bus_io.out_valid  = (state_q == StDone);

endmodule

// File: tb/tb_osd_reliability_sorter.sv
// Directed bench for osd_reliability_sorter (N=8, W=8). The stimulus process loads frames and
// pushes the hand-computed result into a queue; a monitor pops and compares on each accepted
// output and checks the load-to-out_valid latency.
module tb_osd_reliability_sorter;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int IW = 3;
`ifdef OSD_SORTER_EARLY_EXIT_EN
    localparam int LMIN = 2;
`else
    localparam int LMIN = 8;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    osd_reliability_sorter_if #(.N(N), .W(W)) bus ();

    osd_reliability_sorter #(
        .N(N),
        .W(W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector tables: 0 mixed, 1 all equal, 2 ascending, 3 descending, 4 alternating, 5 extremes.
    int llr_t [6][8] = '{
        '{10, -50, 3, -3, 100, 0, -128, 7},
        '{5, 5, 5, 5, 5, 5, 5, 5},
        '{0, 1, 2, 3, 4, 5, 6, 7},
        '{70, 60, 50, 40, 30, 20, 10, 0},
        '{-1, 2, -3, 4, -5, 6, -7, 8},
        '{-128, 127, -127, 1, 0, -1, 2, -2}
    };
    int lam_t [6][8] = '{
        '{6, 4, 1, 0, 7, 2, 3, 5},
        '{0, 1, 2, 3, 4, 5, 6, 7},
        '{7, 6, 5, 4, 3, 2, 1, 0},
        '{0, 1, 2, 3, 4, 5, 6, 7},
        '{7, 6, 5, 4, 3, 2, 1, 0},
        '{0, 1, 2, 6, 7, 3, 5, 4}
    };
    int mag_t [6][8] = '{
        '{128, 100, 50, 10, 7, 3, 3, 0},
        '{5, 5, 5, 5, 5, 5, 5, 5},
        '{7, 6, 5, 4, 3, 2, 1, 0},
        '{70, 60, 50, 40, 30, 20, 10, 0},
        '{8, 7, 6, 5, 4, 3, 2, 1},
        '{128, 127, 127, 2, 2, 1, 1, 0}
    };
    int hd_t [6][8] = '{
        '{1, 0, 1, 0, 0, 0, 1, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 1, 0, 1, 0, 1, 0, 1},
        '{1, 0, 1, 0, 1, 0, 1, 0}
    };

    typedef struct {
        logic [N*IW-1:0] lam;
        logic [N*W-1:0]  mag;
        logic [N-1:0]    hd;
        int              lat_lo;
        int              lat_hi;
        int              load_cyc;
        string           name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [N*W-1:0] pk_w(input int a[8]);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i][7:0];
        return r;
    endfunction

    function automatic logic [N*IW-1:0] pk_i(input int a[8]);
        logic [N*IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*IW +: IW] = a[i][2:0];
        return r;
    endfunction

    function automatic logic [N-1:0] pk_b(input int a[8]);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = a[i][0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Called at posedge+1; leaves at load edge+1 with in_valid low.
    task automatic send(input int k, input int lo, input int hi, input bit push,
                        input string name);
        exp_t e;
        int   guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.llr_flat = pk_w(llr_t[k]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) begin
            e.lam      = pk_i(lam_t[k]);
            e.mag      = pk_w(mag_t[k]);
            e.hd       = pk_b(hd_t[k]);
            e.lat_lo   = lo;
            e.lat_hi   = hi;
            e.load_cyc = cyc;
            e.name     = name;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && bus.in_ready) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: latency on out_valid rise, data on the accepting cycle.
    logic ov_prev = 1'b0;
    exp_t m_e;
    int   m_lat;
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev <= 1'b0;
        end else begin
            if (bus.out_valid && !ov_prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, expected no result");
                end else begin
                    m_lat = cyc - exp_q[0].load_cyc;
                    if (m_lat < exp_q[0].lat_lo || m_lat > exp_q[0].lat_hi) begin
                        n_fail++;
                        $display("FAIL %s_latency: got %0d edges, expected %0d..%0d",
                                 exp_q[0].name, m_lat, exp_q[0].lat_lo, exp_q[0].lat_hi);
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_accept: got a result, expected none queued");
                end else begin
                    m_e = exp_q.pop_front();
                    chk({m_e.name, "_lambda1"}, 64'(bus.lambda1), 64'(m_e.lam));
                    chk({m_e.name, "_mag_sorted"}, 64'(bus.mag_sorted), 64'(m_e.mag));
                    chk({m_e.name, "_hd_perm"}, 64'(bus.hd_perm), 64'(m_e.hd));
                end
            end
            ov_prev <= bus.out_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        bus.in_valid  = 1'b0;
        bus.llr_flat  = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_lambda1", 64'(bus.lambda1), 64'd0);
        chk("rst_mag_sorted", 64'(bus.mag_sorted), 64'd0);
        chk("rst_hd_perm", 64'(bus.hd_perm), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, LMIN, 8, 1'b1, "mixed");
        send(1, LMIN, LMIN, 1'b1, "all_equal");
        send(2, LMIN, 8, 1'b1, "ascending");
        send(3, LMIN, LMIN, 1'b1, "descending");
        drain();

        // Backpressure: result held in DONE while in_valid toggles.
        bus.out_ready = 1'b0;
        send(4, LMIN, 8, 1'b1, "held");
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("held_reached_done", 64'(bus.out_valid), 64'd1);
        bus.llr_flat = pk_w(llr_t[5]);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ((i % 2) == 0);
            @(posedge clk);
            #1;
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_lambda1", 64'(bus.lambda1), 64'(pk_i(lam_t[4])));
            chk("hold_mag_sorted", 64'(bus.mag_sorted), 64'(pk_w(mag_t[4])));
            chk("hold_hd_perm", 64'(bus.hd_perm), 64'(pk_b(hd_t[4])));
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_in_ready", 64'(bus.in_ready), 64'd1);
        chk("accept_out_valid", 64'(bus.out_valid), 64'd0);
        send(5, LMIN, 8, 1'b1, "extremes");
        drain();

        // Reset abort at pass 3: no result may appear for this frame.
        send(0, LMIN, 8, 1'b0, "aborted");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_lambda1", 64'(bus.lambda1), 64'd0);
        chk("abort_mag_sorted", 64'(bus.mag_sorted), 64'd0);
        chk("abort_hd_perm", 64'(bus.hd_perm), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, LMIN, 8, 1'b1, "after_reset");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
